dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of 64-bit words of storage (power of two, minimum 2).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the access wait states inserted between accept and response (range 0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port async_reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  memory-stage request present.
REQ-006 SHALL have port req_ready  output  1  controller can accept a request.
REQ-007 SHALL have port req_write  input  1  1 = write (rmmovq/pushq/call), 0 = read (mrmovq/popq/ret).
REQ-008 SHALL have port req_addr  input  64  byte address.
REQ-009 SHALL have port req_wdata  input  64  write data.
REQ-010 SHALL have port resp_valid  output  1  one-cycle response strobe.
REQ-011 SHALL have port resp_rdata  output  64  read data, valid with resp_valid.
REQ-012 SHALL have port resp_error  output  1  address error (maps to Y86 status SADR), valid with resp_valid.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-014 SHALL accept a request on a rising edge where req_valid & req_ready; it captures write, addr and wdata; req_* are ignored in all other cycles.
REQ-015 SHALL transition IDLE->WAIT on accept when WAIT_CYCLES>0, otherwise IDLE->RESP.
REQ-016 SHALL remain in WAIT for exactly WAIT_CYCLES cycles via a down-counter, then go to RESP; RESP->IDLE unconditionally after one cycle.
REQ-017 SHALL assert resp_valid for exactly one cycle, in RESP; accept at edge N gives resp_valid during cycle N+WAIT_CYCLES+1. No response back-pressure.
REQ-018 SHALL use word index = addr[3 +: log2(DEPTH)]; the address is in range iff addr < DEPTH*8.
REQ-019 SHALL, for an in-range write, update the word on the edge entering RESP; resp_rdata = 0 and resp_error = 0.
REQ-020 SHALL, for an in-range read, present the stored word on resp_rdata with resp_error = 0.
REQ-021 SHALL, for an out-of-range access, leave storage unchanged and drive resp_error = 1 and resp_rdata = 0.
REQ-022 SHALL drive resp_rdata = 0 and resp_error = 0 whenever resp_valid = 0.
REQ-023 SHALL support back-to-back transactions: a request accepted in the IDLE cycle after RESP proceeds normally.
REQ-024 SHALL return the newest data when a read follows a write to the same word.

Reset
REQ-025 SHALL, while async_reset = 0, immediately force state to IDLE, clear the counter and captured request, and drive req_ready = 1, resp_valid = 0, resp_rdata = 0 and resp_error = 0.
REQ-026 SHALL discard an in-flight transaction when reset asserts mid-operation; an uncommitted write SHALL NOT modify storage.
REQ-027 SHALL NOT clear storage on reset; contents are undefined at power-up and retained across reset.

Configuration
REQ-028 SHALL, with DMEM_ALIGN_CHECK_EN defined, flag resp_error = 1 for any access with addr[2:0] != 0 (no storage change); without it, addr[2:0] are ignored.

Structure
REQ-029 SHALL take the state enum, WORD_W=64 and ADDR_W=64 from shared package dmem_pkg.
REQ-030 SHALL place storage in sub-module dmem_array: one synchronous write port and one combinational read port.

Verification
REQ-031 SHALL test write then read: write 0xDEADBEEF_00000001 to 0x40, read 0x40 -> resp_rdata = 0xDEADBEEF_00000001, resp_error = 0, each response 3 cycles after accept (WAIT_CYCLES=2).
REQ-032 SHALL test out of range: read DEPTH*8 = 0x800 -> resp_error = 1, rdata = 0; write 0x800 followed by read 0x0 -> word 0 unchanged.
REQ-033 SHALL test reset mid-WAIT: accept write 0x55 to 0x8, pulse async_reset low in WAIT -> no resp_valid, req_ready = 1 at once, read 0x8 returns prior value.
REQ-034 SHALL test hold: req_valid held high for 10 cycles with changing addr -> only addresses sampled in IDLE cycles are accepted, one resp_valid per accept.
REQ-035 SHALL test alignment: read 0x43 -> with DMEM_ALIGN_CHECK_EN, resp_error = 1; without it, returns word at 0x40.
REQ-036 SHALL test zero wait: WAIT_CYCLES=0, accept at edge N -> resp_valid in cycle N+1, next accept possible at edge N+2.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths and controller state encoding for dmem_ctrl
package dmem_pkg;
  localparam int WORD_W = 64;
  localparam int ADDR_W = 64;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage, one synchronous write port and one combinational read port, never reset
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH];
  // write the addressed word when enabled
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: Y86 data-memory controller with fixed wait states; DMEM_ALIGN_CHECK_EN flags misaligned accesses
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              async_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_error
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WLOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
`ifdef DMEM_ALIGN_CHECK_EN
  localparam logic ALIGN = 1'b1;
`else
  localparam logic ALIGN = 1'b0;
`endif
  state_t            state;
  logic [3:0]        cnt;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              accept, enter_resp, cur_write, err, we;
  logic [ADDR_W-1:0] cur_addr;
  logic [WORD_W-1:0] cur_wdata, rd;
  assign req_ready  = state == IDLE;
  assign accept     = req_valid & req_ready;
  // in IDLE the live request is the one being decided on (zero-wait commits on the accept edge)
  assign cur_write  = (state == IDLE) ? req_write : wr_q;
  assign cur_addr   = (state == IDLE) ? req_addr  : addr_q;
  assign cur_wdata  = (state == IDLE) ? req_wdata : wdata_q;
  assign err        = (|cur_addr[ADDR_W-1:3+AW]) | (ALIGN & (|cur_addr[2:0]));
  assign enter_resp = (accept && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd0);
  assign we         = async_reset & enter_resp & cur_write & ~err;
  assign resp_valid = state == RESP;
  assign resp_error = resp_valid & err;
  assign resp_rdata = (resp_valid && !wr_q && !err) ? rd : '0;
  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (cur_addr[3 +: AW]),
    .wdata (cur_wdata),
    .raddr (cur_addr[3 +: AW]),
    .rdata (rd)
  );
  // request capture, wait-state countdown and IDLE->WAIT->RESP->IDLE sequencing
  always_ff @(posedge clk or negedge async_reset)
    if (!async_reset) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      state   <= (WAIT_CYCLES == 0) ? RESP : WAIT;
      cnt     <= WLOAD;
      wr_q    <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end else if (state == WAIT) begin
      state <= (cnt == 4'd0) ? RESP : WAIT;
      cnt   <= (cnt == 4'd0) ? cnt : cnt - 4'd1;
    end else if (state == RESP) begin
      state <= IDLE;
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scoreboard bench for dmem_ctrl (WAIT_CYCLES=2 main instance, WAIT_CYCLES=0 side instance)
module tb_dmem_ctrl;
  localparam int DEPTH = 256;
  localparam int W = 2;
  logic clk = 1'b0;
  logic async_reset = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, req_ready, resp_valid, resp_error;
  logic [63:0] req_addr = '0, req_wdata = '0, resp_rdata;
  logic v0 = 1'b0, w0 = 1'b0, rdy0, rv0, re0;
  logic [63:0] a0 = '0, d0 = '0, rd0;
  typedef struct {
    logic        w;
    logic [63:0] a;
    logic [63:0] d;
    logic        e;
    int          due;
  } txn_t;
  txn_t sb[$];
  logic [63:0] model [int];
  int cyc = 0, nvec = 0, nerr = 0, nacc = 0, nresp = 0;
  always #5 clk = ~clk;
  dmem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .async_reset(async_reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error)
  );
  dmem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .async_reset(async_reset), .req_valid(v0), .req_ready(rdy0),
    .req_write(w0), .req_addr(a0), .req_wdata(d0),
    .resp_valid(rv0), .resp_rdata(rd0), .resp_error(re0)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic bad(input logic [63:0] a);
    logic b;
    b = a >= 64'(DEPTH * 8);
`ifdef DMEM_ALIGN_CHECK_EN
    b = b | (|a[2:0]);
`endif
    return b;
  endfunction
  always @(posedge clk) begin
    cyc++;
    if (async_reset && req_valid && req_ready) begin
      sb.push_back('{req_write, req_addr, req_wdata, bad(req_addr), cyc + W});
      nacc++;
    end
  end
  always @(negedge clk) begin : mon
    txn_t t;
    int k;
    if (async_reset) begin
      if (resp_valid) begin
        nresp++;
        if (sb.size() == 0) chk("spurious_resp", 64'd1, 64'd0);
        else begin
          t = sb.pop_front();
          k = int'((t.a >> 3) % DEPTH);
          chk("latency", 64'(cyc), 64'(t.due));
          chk("resp_error", 64'(resp_error), 64'(t.e));
          if (t.w || t.e) chk("rdata_zero", resp_rdata, 64'd0);
          else if (model.exists(k)) chk("rdata", resp_rdata, model[k]);
          if (t.w && !t.e) model[k] = t.d;
        end
      end else begin
        chk("idle_rdata", resp_rdata, 64'd0);
        chk("idle_error", 64'(resp_error), 64'd0);
      end
    end
  end
  task automatic send(input logic w, input logic [63:0] a, input logic [63:0] d);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", 64'd0, 64'd1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int a_start, r_start;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_error", 64'(resp_error), 64'd0);
    async_reset = 1'b1;
    send(1'b1, 64'h40, 64'hDEADBEEF_00000001);
    send(1'b0, 64'h40, 64'd0);
    send(1'b1, 64'h0, 64'h0123_4567_89AB_CDEF);
    send(1'b1, 64'h8, 64'h1111);
    send(1'b0, 64'h800, 64'd0);
    send(1'b1, 64'h800, 64'hBAD);
    send(1'b0, 64'h0, 64'd0);
    send(1'b0, 64'h43, 64'd0);
    send(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0);
    for (int i = 0; i < 4; i++) send(1'b1, 64'h200 + 64'(i * 8), {$urandom, $urandom});
    for (int i = 3; i >= 0; i--) send(1'b0, 64'h200 + 64'(i * 8), 64'd0);
    send(1'b1, 64'h7F8, 64'h7777_0000_0000_7777);
    send(1'b0, 64'h7F8, 64'd0);
    drain();
    send(1'b1, 64'h8, 64'h55);
    async_reset = 1'b0;
    #1;
    chk("rst_mid_ready", 64'(req_ready), 64'd1);
    chk("rst_mid_valid", 64'(resp_valid), 64'd0);
    sb.delete();
    @(negedge clk);
    async_reset = 1'b1;
    send(1'b0, 64'h8, 64'd0);
    drain();
    for (int i = 0; i < 4; i++) send(1'b1, 64'h100 + 64'(i * 8), 64'hA0 + 64'(i));
    drain();
    a_start = nacc;
    r_start = nresp;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    for (int i = 0; i < 10; i++) begin
      req_addr = 64'h100 + 64'((i % 4) * 8);
      @(negedge clk);
    end
    req_valid = 1'b0;
    drain();
    chk("hold_accepts", 64'(nacc - a_start), 64'd3);
    chk("hold_resps", 64'(nresp - r_start), 64'(nacc - a_start));
    @(negedge clk);
    v0 = 1'b1;
    w0 = 1'b1;
    a0 = 64'h10;
    d0 = 64'hCAFE_F00D_1234_5678;
    @(posedge clk);
    @(negedge clk);
    chk("zw_valid_n1", 64'(rv0), 64'd1);
    chk("zw_ready_n1", 64'(rdy0), 64'd0);
    chk("zw_wr_rdata", rd0, 64'd0);
    w0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("zw_ready_n2", 64'(rdy0), 64'd1);
    chk("zw_valid_n2", 64'(rv0), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("zw_rd_valid", 64'(rv0), 64'd1);
    chk("zw_rd_rdata", rd0, 64'hCAFE_F00D_1234_5678);
    chk("zw_rd_error", 64'(re0), 64'd0);
    v0 = 1'b0;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
